// File: rtl/seg_pkg.sv
// rtl/seg_pkg.sv - shared constants, state enum and digit type for the 7-segment digit driver
package seg_pkg;

    typedef logic [3:0] bcd_digit_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CONV = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Active-low cathode patterns, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_DIGIT [10] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
        7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
    };

    // 10^n, used to derive the largest value that fits the display
    function automatic logic [63:0] pow10(input int n);
        logic [63:0] p;
        p = 64'd1;
        for (int i = 0; i < n; i++) begin
            p = p * 64'd10;
        end
        return p;
    endfunction

endpackage

// File: rtl/bcd_seg_encode.sv
// rtl/bcd_seg_encode.sv - BCD digit plus blank/dash flags to active-low cathodes
module bcd_seg_encode
    import seg_pkg::*;
(
    input  bcd_digit_t  digit,
    input  logic        blank,
    input  logic        dash,
    output logic [6:0]  seg
);

    // Blank beats dash beats digit; non-decimal nibbles never reach here but show blank
    always_comb begin
        seg = SEG_BLANK;
        if (blank) begin
            seg = SEG_BLANK;
        end else if (dash) begin
            seg = SEG_DASH;
        end else begin
            case (digit)
                4'd0:    seg = SEG_DIGIT[0];
                4'd1:    seg = SEG_DIGIT[1];
                4'd2:    seg = SEG_DIGIT[2];
                4'd3:    seg = SEG_DIGIT[3];
                4'd4:    seg = SEG_DIGIT[4];
                4'd5:    seg = SEG_DIGIT[5];
                4'd6:    seg = SEG_DIGIT[6];
                4'd7:    seg = SEG_DIGIT[7];
                4'd8:    seg = SEG_DIGIT[8];
                4'd9:    seg = SEG_DIGIT[9];
                default: seg = SEG_BLANK;
            endcase
        end
    end

endmodule

// File: rtl/seg_digit_driver.sv
// rtl/seg_digit_driver.sv - binary to BCD double-dabble converter and cathode driver; option LEADING_ZERO_BLANK_EN
module seg_digit_driver
    import seg_pkg::*;
#(
    parameter int WIDTH  = 27,
    parameter int DIGITS = 8
) (
    input  logic              clk_1kHz,
    input  logic              rst,
    input  logic [WIDTH-1:0]  value,
    input  logic              load,
    input  logic [2:0]        current_digit,
    output logic [6:0]        seg,
    output logic              busy,
    output logic              done,
    output logic              ovf
);

    localparam int SW = DIGITS * 4;
    localparam int CW = $clog2(WIDTH + 1);
    localparam int DW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [63:0]   MAX_VAL  = pow10(DIGITS) - 64'd1;
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] shreg;
    logic [SW-1:0]    scratch;
    logic [SW-1:0]    adj;
    logic [SW-1:0]    disp_bcd;
    logic [CW-1:0]    cnt;
    logic             ovf_pend;
    logic             disp_dash;
    logic             ovf_q;
    logic             done_q;
    logic [DIGITS-1:0] lz_blank;
    logic             in_range;
    logic [DW-1:0]    sel;
    bcd_digit_t       cur_nib;
    logic             cur_blank;
    logic             cur_dash;

    // State register
    always_ff @(posedge clk_1kHz) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: one CONV cycle per input bit, then a single DONE cycle
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (load) state_next = ST_CONV;
            ST_CONV: if (cnt == LAST_CNT) state_next = ST_DONE;
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // Double-dabble correction: any BCD nibble of 5 or more gets +3 before the shift
    always_comb begin
        adj = scratch;
        for (int i = 0; i < DIGITS; i++) begin
            if (scratch[i*4 +: 4] >= 4'd5) begin
                adj[i*4 +: 4] = scratch[i*4 +: 4] + 4'd3;
            end
        end
    end

    // Conversion datapath and display register; display only changes in DONE
    always_ff @(posedge clk_1kHz) begin
        if (rst) begin
            shreg     <= '0;
            scratch   <= '0;
            cnt       <= '0;
            ovf_pend  <= 1'b0;
            disp_bcd  <= '0;
            disp_dash <= 1'b0;
            ovf_q     <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (load) begin
                        shreg    <= value;
                        scratch  <= '0;
                        cnt      <= '0;
                        ovf_pend <= (64'(value) > MAX_VAL);
                        ovf_q    <= 1'b0;
                    end
                end
                ST_CONV: begin
                    {scratch, shreg} <= {adj[SW-2:0], shreg, 1'b0};
                    cnt              <= cnt + CW'(1);
                end
                ST_DONE: begin
                    disp_bcd  <= scratch;
                    disp_dash <= ovf_pend;
                    ovf_q     <= ovf_pend;
                    done_q    <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Leading-zero mask: a digit blanks when it and every digit above it are zero
`ifdef LEADING_ZERO_BLANK_EN
    logic lz_run;
    always_comb begin
        lz_blank = '0;
        lz_run   = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            if (disp_bcd[i*4 +: 4] != 4'd0) begin
                lz_run = 1'b0;
            end
            lz_blank[i] = lz_run;
        end
    end
`else
    always_comb begin
        lz_blank = '0;
    end
`endif

    // Digit select straight from current_digit so the cathodes track the anodes with no lag
    always_comb begin
        in_range  = (32'(current_digit) < DIGITS);
        sel       = DW'(current_digit);
        cur_nib   = 4'd0;
        cur_blank = 1'b1;
        cur_dash  = 1'b0;
        if (in_range) begin
            cur_nib   = disp_bcd[{sel, 2'b00} +: 4];
            cur_blank = lz_blank[sel] & ~disp_dash;
            cur_dash  = disp_dash;
        end
    end

    bcd_seg_encode u_encode (
        .digit (cur_nib),
        .blank (cur_blank),
        .dash  (cur_dash),
        .seg   (seg)
    );

    assign busy = (state != ST_IDLE);
    assign done = done_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_seg_digit_driver.sv
// tb/tb_seg_digit_driver.sv - self-checking bench for seg_digit_driver
`timescale 1ns/1ps
module tb_seg_digit_driver;

    logic        clk_1kHz = 1'b0;
    logic        rst;
    logic [26:0] value;
    logic        load;
    logic [2:0]  current_digit;
    logic [6:0]  seg;
    logic        busy;
    logic        done;
    logic        ovf;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int unsigned v;
        bit          ov;
    } sb_item_t;

    sb_item_t sb[$];

    seg_digit_driver #(.WIDTH(27), .DIGITS(8)) dut (
        .clk_1kHz      (clk_1kHz),
        .rst           (rst),
        .value         (value),
        .load          (load),
        .current_digit (current_digit),
        .seg           (seg),
        .busy          (busy),
        .done          (done),
        .ovf           (ovf)
    );

    always #10 clk_1kHz = ~clk_1kHz;

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    function automatic logic [6:0] enc(int n);
        case (n)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    function automatic logic [6:0] exp_seg(int unsigned v, bit ov, int d);
        int unsigned p;
        p = 1;
        for (int i = 0; i < d; i++) p = p * 10;
        if (ov) return 7'b0111111;
`ifdef LEADING_ZERO_BLANK_EN
        if (d > 0 && v < p) return 7'b1111111;
`endif
        return enc(int'((v / p) % 10));
    endfunction

    task automatic tick;
        @(posedge clk_1kHz);
        #1;
    endtask

    task automatic start_load(input int unsigned v, input bit track);
        value = 27'(v);
        load  = 1'b1;
        if (track) sb.push_back('{v: v, ov: (v > 99_999_999)});
        tick;
        load = 1'b0;
    endtask

    task automatic wait_done(output int lat, output int bcnt);
        lat  = 0;
        bcnt = 0;
        while (done !== 1'b1 && lat < 60) begin
            if (busy === 1'b1) bcnt++;
            tick;
            lat++;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; load = 1'b0; value = '0; current_digit = 3'd0;
        tick; tick;
        rst = 1'b0;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", done); end
        total++; if (ovf !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%b exp=0", ovf); end
        for (int d = 0; d < 8; d++) begin
            current_digit = 3'(d); #1;
            total++;
            if (seg !== exp_seg(0, 1'b0, d)) begin
                bad++; $display("FAIL reset_digit%0d got=%b exp=%b", d, seg, exp_seg(0, 1'b0, d));
            end
        end
    endtask

    task automatic test_convert;
        int lat, bcnt;
        sb_item_t it;
        start_load(12_345_678, 1'b1);
        wait_done(lat, bcnt);
        total++; if (lat != 28) begin bad++; $display("FAIL conv_latency got=%0d exp=28", lat); end
        total++; if (bcnt != 28) begin bad++; $display("FAIL conv_busy_cycles got=%0d exp=28", bcnt); end
        total++;
        if (sb.size() == 0) begin bad++; $display("FAIL conv_scoreboard got=empty exp=entry"); end
        else begin
            it = sb.pop_front();
            for (int d = 0; d < 8; d++) begin
                current_digit = 3'(d); #1;
                total++;
                if (seg !== exp_seg(it.v, it.ov, d)) begin
                    bad++; $display("FAIL conv_digit%0d got=%b exp=%b", d, seg, exp_seg(it.v, it.ov, d));
                end
            end
        end
        tick;
        total++; if (done !== 1'b0) begin bad++; $display("FAIL conv_done_clear got=%b exp=0", done); end
    endtask

    task automatic test_load_while_busy;
        int lat, ndone;
        sb_item_t it;
        start_load(12_345_678, 1'b1);
        lat = 0;
        while (done !== 1'b1 && lat < 60) begin
            if (lat == 10) begin value = 27'd99; load = 1'b1; end
            else load = 1'b0;
            tick;
            lat++;
        end
        load = 1'b0;
        total++; if (lat != 28) begin bad++; $display("FAIL busyload_latency got=%0d exp=28", lat); end
        total++;
        if (sb.size() == 0) begin bad++; $display("FAIL busyload_scoreboard got=empty exp=entry"); end
        else begin
            it = sb.pop_front();
            for (int d = 0; d < 8; d++) begin
                current_digit = 3'(d); #1;
                total++;
                if (seg !== exp_seg(it.v, it.ov, d)) begin
                    bad++; $display("FAIL busyload_digit%0d got=%b exp=%b", d, seg, exp_seg(it.v, it.ov, d));
                end
            end
        end
        ndone = 0;
        for (int k = 0; k < 35; k++) begin
            tick;
            if (done === 1'b1) ndone++;
        end
        total++; if (ndone != 0) begin bad++; $display("FAIL busyload_extra_done got=%0d exp=0", ndone); end
        current_digit = 3'd0; #1;
        total++;
        if (seg !== exp_seg(12_345_678, 1'b0, 0)) begin
            bad++; $display("FAIL busyload_held got=%b exp=%b", seg, exp_seg(12_345_678, 1'b0, 0));
        end
    endtask

    task automatic test_overflow;
        int lat, bcnt;
        sb_item_t it;
        start_load(100_000_000, 1'b1);
        wait_done(lat, bcnt);
        total++; if (ovf !== 1'b1) begin bad++; $display("FAIL ovf_flag got=%b exp=1", ovf); end
        total++;
        if (sb.size() == 0) begin bad++; $display("FAIL ovf_scoreboard got=empty exp=entry"); end
        else begin
            it = sb.pop_front();
            for (int d = 0; d < 8; d++) begin
                current_digit = 3'(d); #1;
                total++;
                if (seg !== exp_seg(it.v, it.ov, d)) begin
                    bad++; $display("FAIL ovf_digit%0d got=%b exp=%b", d, seg, exp_seg(it.v, it.ov, d));
                end
            end
        end
        tick;
        start_load(5, 1'b1);
        total++; if (ovf !== 1'b0) begin bad++; $display("FAIL ovf_clear_on_load got=%b exp=0", ovf); end
        wait_done(lat, bcnt);
        total++; if (ovf !== 1'b0) begin bad++; $display("FAIL ovf_after_5 got=%b exp=0", ovf); end
        total++;
        if (sb.size() == 0) begin bad++; $display("FAIL ovf5_scoreboard got=empty exp=entry"); end
        else begin
            it = sb.pop_front();
            for (int d = 0; d < 8; d++) begin
                current_digit = 3'(d); #1;
                total++;
                if (seg !== exp_seg(it.v, it.ov, d)) begin
                    bad++; $display("FAIL ovf5_digit%0d got=%b exp=%b", d, seg, exp_seg(it.v, it.ov, d));
                end
            end
        end
        tick;
    endtask

    task automatic test_reset_abort;
        int lat, bcnt;
        sb_item_t it;
        start_load(12_345_678, 1'b0);
        for (int k = 0; k < 10; k++) tick;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL abort_busy got=%b exp=0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL abort_done got=%b exp=0", done); end
        for (int d = 0; d < 8; d++) begin
            current_digit = 3'(d); #1;
            total++;
            if (seg !== exp_seg(0, 1'b0, d)) begin
                bad++; $display("FAIL abort_digit%0d got=%b exp=%b", d, seg, exp_seg(0, 1'b0, d));
            end
        end
        start_load(42, 1'b1);
        wait_done(lat, bcnt);
        total++; if (lat != 28) begin bad++; $display("FAIL abort42_latency got=%0d exp=28", lat); end
        total++;
        if (sb.size() == 0) begin bad++; $display("FAIL abort42_scoreboard got=empty exp=entry"); end
        else begin
            it = sb.pop_front();
            for (int d = 0; d < 8; d++) begin
                current_digit = 3'(d); #1;
                total++;
                if (seg !== exp_seg(it.v, it.ov, d)) begin
                    bad++; $display("FAIL abort42_digit%0d got=%b exp=%b", d, seg, exp_seg(it.v, it.ov, d));
                end
            end
        end
        tick;
    endtask

    task automatic test_back_to_back;
        int lat, bcnt;
        sb_item_t it;
        start_load(99_999_999, 1'b1);
        wait_done(lat, bcnt);
        total++;
        if (sb.size() == 0) begin bad++; $display("FAIL b2b_scoreboard got=empty exp=entry"); end
        else begin
            it = sb.pop_front();
            for (int d = 0; d < 8; d++) begin
                current_digit = 3'(d); #1;
                total++;
                if (seg !== exp_seg(it.v, it.ov, d)) begin
                    bad++; $display("FAIL b2b_digit%0d got=%b exp=%b", d, seg, exp_seg(it.v, it.ov, d));
                end
            end
        end
        start_load(3_000_607, 1'b1);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL b2b_accept got=%b exp=1", busy); end
        wait_done(lat, bcnt);
        total++; if (lat != 28) begin bad++; $display("FAIL b2b_latency got=%0d exp=28", lat); end
        total++;
        if (sb.size() == 0) begin bad++; $display("FAIL b2b2_scoreboard got=empty exp=entry"); end
        else begin
            it = sb.pop_front();
            for (int d = 0; d < 8; d++) begin
                current_digit = 3'(d); #1;
                total++;
                if (seg !== exp_seg(it.v, it.ov, d)) begin
                    bad++; $display("FAIL b2b2_digit%0d got=%b exp=%b", d, seg, exp_seg(it.v, it.ov, d));
                end
            end
        end
        tick;
    endtask

    initial begin
        rst = 1'b1; load = 1'b0; value = '0; current_digit = 3'd0;
        test_reset;
        test_convert;
        test_load_while_busy;
        test_overflow;
        test_reset_abort;
        test_back_to_back;
        total++; if (sb.size() != 0) begin bad++; $display("FAIL scoreboard_leftover got=%0d exp=0", sb.size()); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
